track_sequencer: RTL and testbench

// Two-track note store/playback engine, directly downstream of the recorder control FSM. Consumes its

---
 rtl/track_sequencer_if.sv | 30 +++
 rtl/track_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_track_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/track_sequencer_if.sv
// Command/status bundle between the recorder control FSM (master) and the two-track sequencer (slave).
// Commands are single-cycle pulses except read, which is a level held for the whole playback.
interface track_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int NOTE_W = 8
);
    logic              write;
    logic              read;
    logic              track1;
    logic              track2;
    logic              mixtrack;
    logic              clean;
    logic [NOTE_W-1:0] swTones;
    logic [NOTE_W-1:0] tone_out;
    logic              finish;
    logic              playing;
    logic              erasing;
    logic              full;
    logic [ADDR_W:0]   note_count;

    modport master (
        output write, read, track1, track2, mixtrack, clean, swTones,
        input  tone_out, finish, playing, erasing, full, note_count
    );

    modport slave (
        input  write, read, track1, track2, mixtrack, clean, swTones,
        output tone_out, finish, playing, erasing, full, note_count
    );
endinterface

// File: rtl/track_sequencer.sv
// Two-track chord store with fixed-tempo playback (single track or OR-mix) and full-memory erase.
// tone_out/finish are registered (1-cycle latency); commands are never stalled, only ignored outside IDLE.
module track_sequencer #(
    parameter int ADDR_W         = 5,
    parameter int NOTE_W         = 8,
    parameter int TICKS_PER_NOTE = 25_000_000
) (
    input  logic             clock,
    input  logic             reset,
    track_sequencer_if.slave bus
);
    localparam int                 DEPTH     = 2 ** ADDR_W;
    localparam int                 TICK_W    = $clog2(TICKS_PER_NOTE);
    localparam logic [ADDR_W:0]    DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICKS_PER_NOTE - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_ERASE} state_e;
    typedef enum logic [1:0] {SEL_T1, SEL_T2, SEL_MIX} sel_e;

    state_e              state_q, state_d;
    sel_e                sel_q, sel_d;
    logic [ADDR_W:0]     len1_q, len1_d;
    logic [ADDR_W:0]     len2_q, len2_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                armed_q, armed_d;
    logic [NOTE_W-1:0]   tone_q, tone_d;
    logic                finish_q, finish_d;

    logic [NOTE_W-1:0]   mem1_q [DEPTH];
    logic [NOTE_W-1:0]   mem2_q [DEPTH];
    logic                we1, we2;
    logic [ADDR_W-1:0]   wr_addr;
    logic [NOTE_W-1:0]   wr_dat;

    logic [ADDR_W:0]     len_mix, len_sel;
    logic [ADDR_W:0]     ptr_ext;
    logic [NOTE_W-1:0]   note1, note2, note_cur;

    assign len_mix = (len1_q > len2_q) ? len1_q : len2_q;
    assign ptr_ext = {1'b0, rd_ptr_q};

    // Notes beyond a track's length are stale RAM, so they are masked out of the mix.
    assign note1 = (ptr_ext < len1_q) ? mem1_q[rd_ptr_q] : '0;
    assign note2 = (ptr_ext < len2_q) ? mem2_q[rd_ptr_q] : '0;

    always_comb begin
        len_sel  = len_mix;
        note_cur = note1 | note2;
        case (sel_q)
            SEL_T1: begin
                len_sel  = len1_q;
                note_cur = mem1_q[rd_ptr_q];
            end
            SEL_T2: begin
                len_sel  = len2_q;
                note_cur = mem2_q[rd_ptr_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        len1_d   = len1_q;
        len2_d   = len2_q;
        rd_ptr_d = rd_ptr_q;
        tick_d   = tick_q;
        addr_d   = addr_q;
        armed_d  = armed_q | ~bus.read;
        tone_d   = '0;
        finish_d = 1'b0;
        we1      = 1'b0;
        we2      = 1'b0;
        wr_addr  = addr_q;
        wr_dat   = '0;

        case (state_q)
            S_IDLE: begin
                tone_d = bus.swTones;
                if (bus.track1)        sel_d = SEL_T1;
                else if (bus.track2)   sel_d = SEL_T2;
                else if (bus.mixtrack) sel_d = SEL_MIX;

                if (bus.clean) begin
                    state_d = S_ERASE;
                    addr_d  = '0;
                    sel_d   = SEL_T1;
                end else if (bus.read && armed_q) begin
                    state_d  = S_PLAY;
                    rd_ptr_d = '0;
                    tick_d   = '0;
                    armed_d  = 1'b0;
                end else if (bus.write) begin
                    wr_dat = bus.swTones;
                    if (sel_q == SEL_T1 && len1_q != DEPTH_L) begin
                        we1     = 1'b1;
                        wr_addr = len1_q[ADDR_W-1:0];
                        len1_d  = len1_q + 1'b1;
                    end else if (sel_q == SEL_T2 && len2_q != DEPTH_L) begin
                        we2     = 1'b1;
                        wr_addr = len2_q[ADDR_W-1:0];
                        len2_d  = len2_q + 1'b1;
                    end
                end
            end

            S_PLAY: begin
                if (!bus.read) begin
                    state_d = S_IDLE;
                end else if (len_sel == '0) begin
                    finish_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tone_d = note_cur;
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (ptr_ext == len_sel - 1'b1) begin
                            finish_d = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            S_ERASE: begin
                we1     = 1'b1;
                we2     = 1'b1;
                wr_addr = addr_q;
                addr_d  = addr_q + 1'b1;
                if (addr_q == ADDR_LAST) begin
                    len1_d  = '0;
                    len2_d  = '0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sel_q    <= SEL_T1;
            len1_q   <= '0;
            len2_q   <= '0;
            rd_ptr_q <= '0;
            tick_q   <= '0;
            addr_q   <= '0;
            armed_q  <= 1'b0;
            tone_q   <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            len1_q   <= len1_d;
            len2_q   <= len2_d;
            rd_ptr_q <= rd_ptr_d;
            tick_q   <= tick_d;
            addr_q   <= addr_d;
            armed_q  <= armed_d;
            tone_q   <= tone_d;
            finish_q <= finish_d;
        end
    end

    // Note RAM has no reset; the zeroed lengths hide whatever it holds.
    always_ff @(posedge clock) begin
        if (we1 && !reset) mem1_q[wr_addr] <= wr_dat;
        if (we2 && !reset) mem2_q[wr_addr] <= wr_dat;
    end

    assign bus.tone_out   = tone_q;
    assign bus.finish     = finish_q;
    assign bus.playing    = (state_q == S_PLAY);
    assign bus.erasing    = (state_q == S_ERASE);
    assign bus.full       = (sel_q != SEL_MIX) && (len_sel == DEPTH_L);
    assign bus.note_count = len_sel;
endmodule

// File: tb/tb_track_sequencer.sv
// Bench for track_sequencer: vector table, hand-written corner sequences and random ops vs a track-queue model.
module tb_track_sequencer;
    localparam int ADDR_W = 3;
    localparam int NOTE_W = 8;
    localparam int TPN    = 4;
    localparam int DEPTH  = 8;

    typedef logic [7:0] notes_t [DEPTH];
    typedef struct {
        bit         t1, t2, mx, wr;
        logic [7:0] sw;
        int         cnt;
        bit         full;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    track_sequencer_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W)) bus ();

    track_sequencer #(
        .ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .TICKS_PER_NOTE(TPN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: two note lists with lengths and the selected view (0=T1, 1=T2, 2=MIX).
    logic [7:0] m1 [DEPTH];
    logic [7:0] m2 [DEPTH];
    int l1 = 0, l2 = 0, msel = 0;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int model_count();
        if (msel == 0) return l1;
        if (msel == 1) return l2;
        return (l1 > l2) ? l1 : l2;
    endfunction

    function automatic int model_full();
        return (msel != 2 && model_count() == DEPTH) ? 1 : 0;
    endfunction

    task automatic model_notes(output notes_t e, output int n);
        n = model_count();
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] a, b;
            a = (i < l1) ? m1[i] : 8'h00;
            b = (i < l2) ? m2[i] : 8'h00;
            e[i] = (msel == 0) ? a : (msel == 1) ? b : (a | b);
        end
    endtask

    task automatic do_sel(input int s);
        bus.track1   = (s == 0);
        bus.track2   = (s == 1);
        bus.mixtrack = (s == 2);
        step();
        bus.track1 = 0; bus.track2 = 0; bus.mixtrack = 0;
        msel = s;
        check("sel_count", bus.note_count, model_count());
        check("sel_full", bus.full, model_full());
    endtask

    task automatic do_write(input logic [7:0] c);
        bus.write   = 1;
        bus.swTones = c;
        step();
        bus.write = 0;
        if (msel == 0 && l1 < DEPTH) begin m1[l1] = c; l1++; end
        else if (msel == 1 && l2 < DEPTH) begin m2[l2] = c; l2++; end
        check("wr_count", bus.note_count, model_count());
        check("wr_full", bus.full, model_full());
        check("wr_monitor", bus.tone_out, c);
    endtask

    task automatic do_clean(input bit with_write, input logic [7:0] c);
        int cnt;
        bus.clean   = 1;
        bus.write   = with_write;
        bus.swTones = c;
        step();
        bus.clean = 0; bus.write = 0;
        cnt = bus.erasing ? 1 : 0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            step();
            if (bus.erasing === 1'b1) cnt++;
        end
        check("erase_cycles", cnt, DEPTH);
        check("erase_tone", bus.tone_out, 0);
        step();
        check("erase_done", bus.erasing, 0);
        check("erase_count", bus.note_count, 0);
        l1 = 0; l2 = 0; msel = 0;
    endtask

    task automatic do_play(input notes_t e, input int n, input bit poke);
        int steps, bad;
        bus.read = 1;
        step();
        check("play_entry", bus.playing, 1);
        if (poke) begin bus.write = 1; bus.swTones = 8'hEE; end
        steps = (n == 0) ? 1 : n * TPN;
        bad = 0;
        for (int k = 1; k <= steps; k++) begin
            step();
            bus.write = 0;
            if (k < steps) begin
                if (bus.finish !== 1'b0 || bus.playing !== 1'b1) bad++;
                check("play_tone", bus.tone_out, e[(k - 1) / TPN]);
            end
        end
        check("play_hold", bad, 0);
        check("finish_pulse", bus.finish, 1);
        check("play_exit", bus.playing, 0);
        check("last_tone", bus.tone_out, (n == 0) ? 8'h00 : e[n - 1]);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.finish !== 1'b0 || bus.playing !== 1'b0) bad++;
        end
        check("no_replay", bad, 0);
        bus.read = 0;
        step();
        check("count_after_play", bus.note_count, model_count());
    endtask

    task automatic set_vec(input int i, input bit t1, input bit t2, input bit mx, input bit wr,
                           input logic [7:0] sw, input int cnt, input bit full);
        tbl[i].t1 = t1; tbl[i].t2 = t2; tbl[i].mx = mx; tbl[i].wr = wr;
        tbl[i].sw = sw; tbl[i].cnt = cnt; tbl[i].full = full;
    endtask

    initial begin
        notes_t e, ch;
        int bad, r, rn;

        bus.write = 0; bus.read = 0; bus.track1 = 0; bus.track2 = 0;
        bus.mixtrack = 0; bus.clean = 0; bus.swTones = 8'h00;

        ch = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        set_vec(0, 1, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < DEPTH; i++) set_vec(i + 1, 0, 0, 0, 1, ch[i], i + 1, (i == DEPTH - 1));
        set_vec(9,  0, 0, 0, 1, 8'hFF, 8, 1);
        set_vec(10, 0, 1, 0, 0, 8'h00, 0, 0);
        set_vec(11, 0, 0, 0, 1, 8'h3C, 1, 0);
        set_vec(12, 0, 0, 1, 0, 8'h00, 8, 0);
        set_vec(13, 0, 0, 0, 1, 8'h5A, 8, 0);
        set_vec(14, 1, 0, 0, 0, 8'h00, 8, 1);

        // Reset state
        repeat (3) step();
        check("rst_tone", bus.tone_out, 0);
        check("rst_finish", bus.finish, 0);
        check("rst_playing", bus.playing, 0);
        check("rst_erasing", bus.erasing, 0);
        check("rst_count", bus.note_count, 0);
        check("rst_full", bus.full, 0);
        reset = 0;
        step();

        // Record three notes on track 1 and play them back
        do_sel(0);
        do_write(8'h01); do_write(8'h02); do_write(8'h04);
        e = '{8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_play(e, 3, 0);

        // Track 2 plus mix playback
        do_sel(1);
        do_write(8'h80); do_write(8'h40);
        do_sel(2);
        check("mix_count", bus.note_count, 3);
        e = '{8'h81, 8'h42, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_play(e, 3, 0);

        // Abort by dropping read in the middle of the second note
        bus.read = 1;
        step();
        repeat (6) step();
        check("abort_pre_tone", bus.tone_out, 8'h42);
        bus.read = 0;
        step();
        check("abort_playing", bus.playing, 0);
        check("abort_finish", bus.finish, 0);
        check("abort_tone", bus.tone_out, 0);
        step();
        check("abort_no_finish", bus.finish, 0);

        // Vector table: fill to depth, overflow, per-track counts, mix drops writes
        do_clean(0, 8'h00);
        for (int i = 0; i < 15; i++) begin
            bus.track1 = tbl[i].t1; bus.track2 = tbl[i].t2; bus.mixtrack = tbl[i].mx;
            bus.write = tbl[i].wr; bus.swTones = tbl[i].sw;
            step();
            bus.track1 = 0; bus.track2 = 0; bus.mixtrack = 0; bus.write = 0;
            check($sformatf("vec%0d_count", i), bus.note_count, tbl[i].cnt);
            check($sformatf("vec%0d_full", i), bus.full, tbl[i].full);
            check($sformatf("vec%0d_tone", i), bus.tone_out, tbl[i].sw);
        end
        for (int i = 0; i < DEPTH; i++) m1[i] = ch[i];
        l1 = 8; m2[0] = 8'h3C; l2 = 1; msel = 0;
        do_play(ch, 8, 0);
        do_sel(2);
        e = ch; e[0] = 8'hBD;
        do_play(e, 8, 0);
        do_sel(1);
        e = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_play(e, 1, 1);
        check("write_in_play_ignored", bus.note_count, 1);

        // Clean with read held: erase, then an empty playback
        bus.read = 1; bus.clean = 1;
        step();
        bus.clean = 0;
        check("cr_erasing", bus.erasing, 1);
        bad = 0;
        repeat (7) begin step(); if (bus.erasing !== 1'b1) bad++; end
        check("cr_erase_hold", bad, 0);
        step();
        check("cr_erase_end", bus.erasing, 0);
        check("cr_count", bus.note_count, 0);
        check("cr_idle", bus.playing, 0);
        step();
        check("cr_play", bus.playing, 1);
        step();
        check("cr_finish", bus.finish, 1);
        check("cr_tone", bus.tone_out, 0);
        check("cr_exit", bus.playing, 0);
        step();
        check("cr_finish_pulse", bus.finish, 0);
        bus.read = 0;
        step();
        l1 = 0; l2 = 0; msel = 0;

        // Clean and write in the same cycle
        do_write(8'h5A);
        do_clean(1, 8'h77);
        e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_play(e, 0, 0);

        // Reset in the middle of playback
        do_write(8'h12); do_write(8'h34);
        bus.read = 1;
        step();
        repeat (5) step();
        check("rp_tone", bus.tone_out, 8'h34);
        reset = 1;
        step();
        check("rp_tone0", bus.tone_out, 0);
        check("rp_finish", bus.finish, 0);
        check("rp_playing", bus.playing, 0);
        check("rp_erasing", bus.erasing, 0);
        check("rp_count", bus.note_count, 0);
        check("rp_full", bus.full, 0);
        reset = 0; bus.read = 0;
        step();
        l1 = 0; l2 = 0; msel = 0;

        // Random operations against the model
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 1)      do_sel($urandom_range(0, 2));
            else if (r <= 6) do_write(8'($urandom_range(0, 255)));
            else if (r == 7) do_clean(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            else begin
                model_notes(e, rn);
                do_play(e, rn, 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
